branch_resolver: RTL and testbench
==================================

# branch_resolver

Parametrised branch-resolution unit for the instruction-decode stage of the MIPS-DLX pipeline. It generalises the single equality compare to eight compare modes at configurable width. It waits, with a stall request, until forwarded operands are final, then computes the taken/not-taken decision and the target PC. It presents a registered result to fetch, held across downstream stalls.

## Interface
- `BUS_SIZE`, 32, operand width
- `PC_SIZE`, 32, program-counter width
- `MAX_WAIT`, 7, maximum cycles spent waiting for operands before `wait_err` (1..255)
- `clk` in 1 — single clock, rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `br_valid` in 1 — ID holds a branch this cycle
- `br_mode` in 3 — compare mode: 0 EQ, 1 NE, 2 LTZ, 3 GEZ, 4 LEZ, 5 GTZ, 6 LT signed, 7 LTU
- `a`, `b` in BUS_SIZE — operands after forwarding mux
- `ops_ready` in 1 — forwarding unit: `a`/`b` are final
- `pc_next` in PC_SIZE — PC+4 of the branch
- `offset` in PC_SIZE — sign-extended, pre-shifted branch offset
- `ex_stall` in 1 — downstream holds fetch; result must not be consumed
- `stall_id` out 1 — request to freeze IF/ID
- `br_done` out 1 — result valid
- `br_taken` out 1 — decision
- `br_target` out PC_SIZE — next PC
- `flush_if` out 1 — kill the instruction fetched after the branch
- `wait_err` out 1 — sticky; operand wait exceeded `MAX_WAIT`

## Operation
- Decision, from `a` and `b` as sampled:
  - EQ: a==b. NE: a!=b.
  - LTZ: a[MSB]. GEZ: !a[MSB]. LEZ: a[MSB] | (a==0). GTZ: !a[MSB] & (a!=0). Zero-compare modes ignore `b`.
  - LT: signed a<b. LTU: unsigned a<b.
- Target: pc_next+offset, truncated to PC_SIZE (wraps silently), when taken; otherwise pc_next.
- FSM states: IDLE, WAIT, DONE, HOLD.
  - IDLE: `br_valid`&`ops_ready` → capture decision/target, go to DONE. `br_valid`&!`ops_ready` → WAIT, clear wait counter. Otherwise stay.
  - WAIT: `stall_id`=1, counter increments each cycle. `ops_ready` → capture, go to DONE. Counter reaching `MAX_WAIT` sets `wait_err`; the state stays WAIT (never abandons the branch).
  - DONE: `br_done`=1 for this cycle, `flush_if`=`br_taken`. `ex_stall`=0 → IDLE, or, if a new `br_valid`&`ops_ready` is present, capture it and stay in DONE (back-to-back branches). `ex_stall`=1 → HOLD.
  - HOLD: `br_done`, `br_taken`, `br_target` held, `flush_if`=0, `stall_id`=1. `ex_stall`=0 → IDLE.
- `br_valid` in HOLD or WAIT is not a new branch; ID is frozen, so it is the same instruction.
- `wait_err` clears only on reset.

## Timing
- Reset: state IDLE, `br_done`=0, `br_taken`=0, `br_target`=0, `flush_if`=0, `stall_id`=0, `wait_err`=0, wait counter 0.
- Latency: operands ready at edge N → `br_done` high after edge N+1; outputs are registered.
- `stall_id` is combinational from state and inputs: high in IDLE when `br_valid`&!`ops_ready`, in all of WAIT, and in HOLD.
- `flush_if` is a single-cycle pulse per taken branch, even when followed by HOLD.
- Simultaneous `ops_ready` and counter reaching `MAX_WAIT`: capture wins; `wait_err` is still set.
- Reset asserted mid-WAIT or mid-HOLD: outputs return to reset values immediately (asynchronous); the branch is discarded.

## Structure
- Shared package `dlx_pkg`: `br_mode` localparam encodings (`BR_EQ`…`BR_LTU`) and the FSM state enum, reused by the decoder.
- Sub-module `branch_cmp`: purely combinational, parameter `BUS_SIZE`, inputs `a`, `b`, mode; output taken. It replaces the old equality comparer.
- The top level holds the FSM, wait counter (width $clog2(MAX_WAIT+1)), capture registers and target adder.

## Test plan
- Mode sweep, BUS_SIZE=32: a=0xFFFFFFFF, b=1. Expect LT=1, LTU=0, LTZ=1, GEZ=0, LEZ=1, GTZ=0, EQ=0, NE=1. a=0 with LEZ=1, GTZ=0.
- Taken EQ: a=b=5, pc_next=0x100, offset=0x20, ops_ready=1 → next cycle `br_done`=1, `br_taken`=1, `br_target`=0x120, `flush_if`=1 for one cycle.
- Wrap: pc_next=0xFFFFFFFC, offset=8, taken → `br_target`=0x00000004. Not taken → target=pc_next, `flush_if`=0.
- Operand wait: `ops_ready` low 3 cycles → `stall_id`=1 for those 3, `br_done` one cycle after ready, `wait_err`=0. Low for 8 cycles with MAX_WAIT=7 → `wait_err`=1 and stays set.
- Downstream stall: `ex_stall`=1 for 4 cycles during DONE → outputs stable, `flush_if` pulses once, `stall_id`=1 in HOLD, IDLE after release.
- `rst_n` pulsed low in WAIT → all outputs 0 without a clock edge, FSM IDLE; the next branch resolves normally.

Source files
------------

// File: rtl/dlx_pkg.sv
// Shared DLX decode definitions: branch compare-mode encodings and the
// branch-resolution FSM state type.
package dlx_pkg;

    localparam logic [2:0] BR_EQ  = 3'd0;
    localparam logic [2:0] BR_NE  = 3'd1;
    localparam logic [2:0] BR_LTZ = 3'd2;
    localparam logic [2:0] BR_GEZ = 3'd3;
    localparam logic [2:0] BR_LEZ = 3'd4;
    localparam logic [2:0] BR_GTZ = 3'd5;
    localparam logic [2:0] BR_LT  = 3'd6;
    localparam logic [2:0] BR_LTU = 3'd7;

    typedef enum logic [1:0] {
        BR_IDLE = 2'd0,
        BR_WAIT = 2'd1,
        BR_DONE = 2'd2,
        BR_HOLD = 2'd3
    } br_state_e;

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator; zero-compare modes look only at a.
module branch_cmp
    import dlx_pkg::*;
#(
    parameter int unsigned BUS_SIZE = 32
) (
    input  logic [BUS_SIZE-1:0] a,
    input  logic [BUS_SIZE-1:0] b,
    input  logic [2:0]          mode,
    output logic                taken
);

    logic a_neg;
    logic a_zero;

    always_comb begin
        a_neg  = a[BUS_SIZE-1];
        a_zero = (a == '0);
        taken  = 1'b0;
        case (mode)
            BR_EQ:   taken = (a == b);
            BR_NE:   taken = (a != b);
            BR_LTZ:  taken = a_neg;
            BR_GEZ:  taken = !a_neg;
            BR_LEZ:  taken = a_neg | a_zero;
            BR_GTZ:  taken = !a_neg & !a_zero;
            BR_LT:   taken = ($signed(a) < $signed(b));
            BR_LTU:  taken = (a < b);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// ID-stage branch resolution: waits for final operands, registers the
// decision and target, and holds them while downstream is stalled.
module branch_resolver
    import dlx_pkg::*;
#(
    parameter int unsigned BUS_SIZE = 32,
    parameter int unsigned PC_SIZE  = 32,
    parameter int unsigned MAX_WAIT = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                br_valid,
    input  logic [2:0]          br_mode,
    input  logic [BUS_SIZE-1:0] a,
    input  logic [BUS_SIZE-1:0] b,
    input  logic                ops_ready,
    input  logic [PC_SIZE-1:0]  pc_next,
    input  logic [PC_SIZE-1:0]  offset,
    input  logic                ex_stall,
    output logic                stall_id,
    output logic                br_done,
    output logic                br_taken,
    output logic [PC_SIZE-1:0]  br_target,
    output logic                flush_if,
    output logic                wait_err
);

    localparam int unsigned    CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_WAIT);

    br_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               taken_q, taken_d;
    logic [PC_SIZE-1:0] target_q, target_d;
    logic               flush_q, flush_d;
    logic               err_q, err_d;

    logic               cmp_taken;
    logic [PC_SIZE-1:0] cap_target;
    logic               capture;

    branch_cmp #(.BUS_SIZE(BUS_SIZE)) u_cmp (
        .a     (a),
        .b     (b),
        .mode  (br_mode),
        .taken (cmp_taken)
    );

    assign cap_target = cmp_taken ? (pc_next + offset) : pc_next;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        taken_d  = taken_q;
        target_d = target_q;
        flush_d  = 1'b0;
        err_d    = err_q;
        stall_id = 1'b0;
        capture  = 1'b0;

        case (state_q)
            BR_IDLE: begin
                done_d = 1'b0;
                if (br_valid && ops_ready) begin
                    capture = 1'b1;
                end else if (br_valid) begin
                    stall_id = 1'b1;
                    cnt_d    = '0;
                    state_d  = BR_WAIT;
                end
            end
            BR_WAIT: begin
                stall_id = 1'b1;
                // Error is flagged even when ready arrives on the same cycle.
                if (cnt_q == CNT_LAST) err_d = 1'b1;
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                if (ops_ready) capture = 1'b1;
            end
            BR_DONE: begin
                if (ex_stall) begin
                    state_d = BR_HOLD;
                end else if (br_valid && ops_ready) begin
                    capture = 1'b1;
                end else begin
                    done_d  = 1'b0;
                    state_d = BR_IDLE;
                end
            end
            BR_HOLD: begin
                stall_id = 1'b1;
                if (!ex_stall) begin
                    done_d  = 1'b0;
                    state_d = BR_IDLE;
                end
            end
            default: state_d = BR_IDLE;
        endcase

        if (capture) begin
            done_d   = 1'b1;
            taken_d  = cmp_taken;
            target_d = cap_target;
            flush_d  = cmp_taken;
            state_d  = BR_DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= BR_IDLE;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            taken_q  <= 1'b0;
            target_q <= '0;
            flush_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            taken_q  <= taken_d;
            target_q <= target_d;
            flush_q  <= flush_d;
            err_q    <= err_d;
        end
    end

    assign br_done   = done_q;
    assign br_taken  = taken_q;
    assign br_target = target_q;
    assign flush_if  = flush_q;
    assign wait_err  = err_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: back-to-back vector table with a
// result scoreboard, plus wait, downstream-stall and reset sequences.
module tb_branch_resolver;
    import dlx_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         br_valid = 1'b0;
    logic [2:0]   br_mode = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ops_ready = 1'b0;
    logic [W-1:0] pc_next = '0;
    logic [W-1:0] offset = '0;
    logic         ex_stall = 1'b0;
    logic         stall_id, br_done, br_taken, flush_if, wait_err;
    logic [W-1:0] br_target;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [2:0] mode;
        logic [31:0] a, b, pc, off;
        logic        exp_taken;
        logic [31:0] exp_target;
    } vec_t;

    typedef struct {
        string       name;
        logic        taken;
        logic [31:0] target;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    branch_resolver #(.BUS_SIZE(W), .PC_SIZE(W), .MAX_WAIT(7)) dut (
        .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_mode(br_mode),
        .a(a), .b(b), .ops_ready(ops_ready), .pc_next(pc_next), .offset(offset),
        .ex_stall(ex_stall), .stall_id(stall_id), .br_done(br_done),
        .br_taken(br_taken), .br_target(br_target), .flush_if(flush_if),
        .wait_err(wait_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", n, act, exp);
        end
    endtask

    function automatic vec_t mkv(input string n, input logic [2:0] m, input logic [31:0] va,
                                 input logic [31:0] vb, input logic [31:0] pc,
                                 input logic [31:0] off, input logic t, input logic [31:0] tgt);
        vec_t v;
        v.name = n; v.mode = m; v.a = va; v.b = vb; v.pc = pc; v.off = off;
        v.exp_taken = t; v.exp_target = tgt;
        return v;
    endfunction

    task automatic drive_branch(input string n, input logic [2:0] m, input logic [31:0] va,
                                input logic [31:0] vb, input logic [31:0] pc,
                                input logic [31:0] off, input logic rdy,
                                input logic t, input logic [31:0] tgt);
        exp_t e;
        br_valid = 1'b1; br_mode = m; a = va; b = vb; pc_next = pc; offset = off;
        ops_ready = rdy;
        if (rdy) begin
            e.name = n; e.taken = t; e.target = tgt;
            sb_q.push_back(e);
        end
    endtask

    task automatic check_pop();
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard: got result with empty queue required pending entry");
        end else begin
            e = sb_q.pop_front();
            chk({e.name, "_done"},   32'(br_done),  32'd1);
            chk({e.name, "_taken"},  32'(br_taken), 32'(e.taken));
            chk({e.name, "_target"}, br_target,     e.target);
            chk({e.name, "_flush"},  32'(flush_if), 32'(e.taken));
        end
    endtask

    task automatic check_idle(input string n, input logic err);
        chk({n, "_done"},  32'(br_done),  32'd0);
        chk({n, "_flush"}, 32'(flush_if), 32'd0);
        chk({n, "_stall"}, 32'(stall_id), 32'd0);
        chk({n, "_err"},   32'(wait_err), 32'(err));
    endtask

    initial begin
        vecs.push_back(mkv("sw_eq",  BR_EQ,  32'hFFFFFFFF, 32'd1, 32'h1000, 32'h40, 1'b0, 32'h1000));
        vecs.push_back(mkv("sw_ne",  BR_NE,  32'hFFFFFFFF, 32'd1, 32'h1000, 32'h40, 1'b1, 32'h1040));
        vecs.push_back(mkv("sw_ltz", BR_LTZ, 32'hFFFFFFFF, 32'd1, 32'h1000, 32'h40, 1'b1, 32'h1040));
        vecs.push_back(mkv("sw_gez", BR_GEZ, 32'hFFFFFFFF, 32'd1, 32'h1000, 32'h40, 1'b0, 32'h1000));
        vecs.push_back(mkv("sw_lez", BR_LEZ, 32'hFFFFFFFF, 32'd1, 32'h1000, 32'h40, 1'b1, 32'h1040));
        vecs.push_back(mkv("sw_gtz", BR_GTZ, 32'hFFFFFFFF, 32'd1, 32'h1000, 32'h40, 1'b0, 32'h1000));
        vecs.push_back(mkv("sw_lt",  BR_LT,  32'hFFFFFFFF, 32'd1, 32'h1000, 32'h40, 1'b1, 32'h1040));
        vecs.push_back(mkv("sw_ltu", BR_LTU, 32'hFFFFFFFF, 32'd1, 32'h1000, 32'h40, 1'b0, 32'h1000));
        vecs.push_back(mkv("z_lez",  BR_LEZ, 32'd0, 32'd7, 32'h1000, 32'h40, 1'b1, 32'h1040));
        vecs.push_back(mkv("z_gtz",  BR_GTZ, 32'd0, 32'd7, 32'h1000, 32'h40, 1'b0, 32'h1000));
        vecs.push_back(mkv("p_gtz",  BR_GTZ, 32'd3, 32'd0, 32'h1000, 32'h40, 1'b1, 32'h1040));
        vecs.push_back(mkv("s_lt",   BR_LT,  32'd2, 32'hFFFFFFFF, 32'h1000, 32'h40, 1'b0, 32'h1000));
        vecs.push_back(mkv("u_ltu",  BR_LTU, 32'd2, 32'hFFFFFFFF, 32'h1000, 32'h40, 1'b1, 32'h1040));
        vecs.push_back(mkv("eq_tk",  BR_EQ,  32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 32'h120));
        vecs.push_back(mkv("wrap_t", BR_EQ,  32'd5, 32'd5, 32'hFFFFFFFC, 32'd8, 1'b1, 32'h4));
        vecs.push_back(mkv("wrap_n", BR_NE,  32'd5, 32'd5, 32'hFFFFFFFC, 32'd8, 1'b0, 32'hFFFFFFFC));
        vecs.push_back(mkv("gez_mx", BR_GEZ, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h1000, 32'h40, 1'b1, 32'h1040));

        // Reset values
        #12;
        chk("rst_target", br_target, 32'd0);
        chk("rst_taken", 32'(br_taken), 32'd0);
        check_idle("rst", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back table: each result is checked while the next branch is driven
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            if (i > 0) check_pop();
            drive_branch(vecs[i].name, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].pc,
                         vecs[i].off, 1'b1, vecs[i].exp_taken, vecs[i].exp_target);
        end
        @(negedge clk);
        check_pop();
        br_valid = 1'b0; ops_ready = 1'b0;
        @(negedge clk);
        check_idle("tbl_end", 1'b0);

        // Short operand wait: three not-ready cycles
        drive_branch("wait3", BR_EQ, 32'd5, 32'd5, 32'h200, 32'h10, 1'b0, 1'b0, 32'h0);
        #1 chk("wait3_stall_idle", 32'(stall_id), 32'd1);
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            chk("wait3_stall", 32'(stall_id), 32'd1);
            chk("wait3_done", 32'(br_done), 32'd0);
        end
        @(negedge clk);
        drive_branch("wait3", BR_EQ, 32'd5, 32'd5, 32'h200, 32'h10, 1'b1, 1'b1, 32'h210);
        #1 chk("wait3_stall_rdy", 32'(stall_id), 32'd1);
        @(negedge clk);
        check_pop();
        chk("wait3_err", 32'(wait_err), 32'd0);
        br_valid = 1'b0; ops_ready = 1'b0;
        @(negedge clk);
        check_idle("wait3_end", 1'b0);

        // Downstream stall across DONE and HOLD
        ex_stall = 1'b1;
        drive_branch("hold", BR_NE, 32'd1, 32'd2, 32'h300, 32'h44, 1'b1, 1'b1, 32'h344);
        @(negedge clk);
        check_pop();
        chk("hold_done_stall", 32'(stall_id), 32'd0);
        br_valid = 1'b0; ops_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("hold_done",   32'(br_done),  32'd1);
            chk("hold_taken",  32'(br_taken), 32'd1);
            chk("hold_target", br_target,     32'h344);
            chk("hold_flush",  32'(flush_if), 32'd0);
            chk("hold_stall",  32'(stall_id), 32'd1);
        end
        ex_stall = 1'b0;
        @(negedge clk);
        check_idle("hold_end", 1'b0);

        // Long wait: eight not-ready cycles with MAX_WAIT=7
        drive_branch("wait8", BR_LTU, 32'd1, 32'd2, 32'h400, 32'h8, 1'b0, 1'b0, 32'h0);
        for (int j = 1; j < 8; j++) begin
            @(negedge clk);
            if (j == 3) chk("wait8_err_early", 32'(wait_err), 32'd0);
        end
        @(negedge clk);
        chk("wait8_err_set", 32'(wait_err), 32'd1);
        chk("wait8_stall", 32'(stall_id), 32'd1);
        drive_branch("wait8", BR_LTU, 32'd1, 32'd2, 32'h400, 32'h8, 1'b1, 1'b1, 32'h408);
        @(negedge clk);
        check_pop();
        br_valid = 1'b0; ops_ready = 1'b0;
        @(negedge clk);
        check_idle("wait8_sticky", 1'b1);

        // Asynchronous reset in the middle of WAIT
        drive_branch("rstw", BR_EQ, 32'd1, 32'd1, 32'h500, 32'h4, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        #2;
        br_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstw_target", br_target, 32'd0);
        chk("rstw_taken", 32'(br_taken), 32'd0);
        check_idle("rstw", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive_branch("post_rst", BR_GEZ, 32'd0, 32'hFFFFFFFF, 32'h500, 32'h100, 1'b1, 1'b1, 32'h600);
        #1 chk("post_rst_stall", 32'(stall_id), 32'd0);
        @(negedge clk);
        check_pop();
        br_valid = 1'b0; ops_ready = 1'b0;
        @(negedge clk);
        check_idle("post_rst_end", 1'b0);

        if (sb_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
